lcd_byte_writer: RTL and testbench

LCD_BYTE_WRITER -- requirements
Module: lcd_byte_writer

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_byte_writer_if.sv | 16 +
 rtl/lcd_delay_counter.sv | 27 ++
 rtl/lcd_byte_writer.sv | 135 +++++++++++++
 tb/tb_lcd_byte_writer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: byte-writer state encoding and default HD44780-style
// timing (clocks at 50 MHz), also used by the power-on init controller.
package lcd_pkg;

  localparam int LCD_E_PULSE_CYCLES    = 12;
  localparam int LCD_SETUP_CYCLES      = 2;
  localparam int LCD_NIBBLE_GAP_CYCLES = 50;
  localparam int LCD_BYTE_GAP_CYCLES   = 2000;
  localparam int LCD_CLEAR_GAP_CYCLES  = 82000;
  localparam int LCD_CNT_W             = 17;

  typedef logic [LCD_CNT_W-1:0] lcd_count_t;
  typedef logic [7:0]           lcd_byte_t;
  typedef logic [3:0]           lcd_nibble_t;

  typedef enum logic [2:0] {
    LCD_IDLE     = 3'd0,
    LCD_HI_SETUP = 3'd1,
    LCD_HI_PULSE = 3'd2,
    LCD_NIB_GAP  = 3'd3,
    LCD_LO_SETUP = 3'd4,
    LCD_LO_PULSE = 3'd5,
    LCD_BYTE_GAP = 3'd6,
    LCD_DONE     = 3'd7
  } lcd_wr_state_e;

  // Clear display (0x01) and return home (0x02) need the long post-wait.
  function automatic logic lcd_is_slow_cmd(input logic rs, input lcd_byte_t data);
    return !rs && ((data == 8'h01) || (data == 8'h02));
  endfunction

endpackage

// File: rtl/lcd_byte_writer_if.sv
// Byte request channel into the LCD byte writer.
// valid/ready: a byte transfers on a rising Clock edge where valid=1 and
// ready=1; rs/data must be stable at that edge; done pulses once per byte.
interface lcd_byte_writer_if;
  import lcd_pkg::*;

  logic      valid;
  logic      rs;
  lcd_byte_t data;
  logic      ready;
  logic      done;

  modport master (output valid, output rs, output data, input ready, input done);
  modport slave  (input valid, input rs, input data, output ready, output done);

endinterface

// File: rtl/lcd_delay_counter.sv
// Dwell down-counter: loads on state entry, expired flags the last cycle of
// the dwell (count == 1); holds at 0 when idle.
module lcd_delay_counter #(
  parameter int W = 17
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count > W'(1)) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/lcd_byte_writer.sv
// Writes one byte to a 4-bit LCD bus as two E-strobed nibbles, then waits.
// Build option LCD_CLEAR_DELAY_EN: long post-wait for clear/home commands.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYCLES    = LCD_E_PULSE_CYCLES,
  parameter int SETUP_CYCLES      = LCD_SETUP_CYCLES,
  parameter int NIBBLE_GAP_CYCLES = LCD_NIBBLE_GAP_CYCLES,
  parameter int BYTE_GAP_CYCLES   = LCD_BYTE_GAP_CYCLES,
  parameter int CLEAR_GAP_CYCLES  = LCD_CLEAR_GAP_CYCLES
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iValid,
  input  logic          iRS,
  input  lcd_byte_t     iData,
  output logic          oReady,
  output logic          oDone,
  output logic          oLCD_Enabled,
  output logic          oLCD_RegisterSelect,
  output lcd_nibble_t   oLCD_Data,
  output logic          oLCD_ReadWrite,
  output logic          oLCD_StrataFlashControl,
  output lcd_wr_state_e oDebugState
);

  localparam int MaxDwell = (1 << LCD_CNT_W) - 1;

  // A zero dwell would never reach 1 and hang the state machine.
  localparam bit CfgOk =
    (E_PULSE_CYCLES    >= 1) && (E_PULSE_CYCLES    <= MaxDwell) &&
    (SETUP_CYCLES      >= 1) && (SETUP_CYCLES      <= MaxDwell) &&
    (NIBBLE_GAP_CYCLES >= 1) && (NIBBLE_GAP_CYCLES <= MaxDwell) &&
    (BYTE_GAP_CYCLES   >= 1) && (BYTE_GAP_CYCLES   <= MaxDwell) &&
    (CLEAR_GAP_CYCLES  >= 1) && (CLEAR_GAP_CYCLES  <= MaxDwell);

  if (!CfgOk) begin : g_bad_cfg
    $error("lcd_byte_writer: every dwell must be within 1..2^17-1 clocks");
  end

  lcd_wr_state_e state;
  lcd_wr_state_e nextState;
  lcd_byte_t     dataReg;
  logic          rsReg;
  logic          accept;
  logic          load;
  logic          expired;
  lcd_count_t    loadValue;
  lcd_count_t    postWait;
  lcd_byte_t     byteNext;
  logic          rsNext;

  assign accept   = (state == LCD_IDLE) && iValid;
  assign byteNext = accept ? iData : dataReg;
  assign rsNext   = accept ? iRS : rsReg;

`ifdef LCD_CLEAR_DELAY_EN
  assign postWait = lcd_is_slow_cmd(rsReg, dataReg) ? lcd_count_t'(CLEAR_GAP_CYCLES)
                                                    : lcd_count_t'(BYTE_GAP_CYCLES);
`else
  assign postWait = lcd_count_t'(BYTE_GAP_CYCLES);
`endif

  always_comb begin
    nextState = state;
    case (state)
      LCD_IDLE:     if (iValid)  nextState = LCD_HI_SETUP;
      LCD_HI_SETUP: if (expired) nextState = LCD_HI_PULSE;
      LCD_HI_PULSE: if (expired) nextState = LCD_NIB_GAP;
      LCD_NIB_GAP:  if (expired) nextState = LCD_LO_SETUP;
      LCD_LO_SETUP: if (expired) nextState = LCD_LO_PULSE;
      LCD_LO_PULSE: if (expired) nextState = LCD_BYTE_GAP;
      LCD_BYTE_GAP: if (expired) nextState = LCD_DONE;
      LCD_DONE:     if (expired) nextState = LCD_IDLE;
    endcase
  end

  // Counter reloads with the dwell of whichever state is being entered.
  always_comb begin
    load      = (nextState != state);
    loadValue = '0;
    case (nextState)
      LCD_HI_SETUP, LCD_LO_SETUP: loadValue = lcd_count_t'(SETUP_CYCLES);
      LCD_HI_PULSE, LCD_LO_PULSE: loadValue = lcd_count_t'(E_PULSE_CYCLES);
      LCD_NIB_GAP:                loadValue = lcd_count_t'(NIBBLE_GAP_CYCLES);
      LCD_BYTE_GAP:               loadValue = postWait;
      LCD_DONE:                   loadValue = lcd_count_t'(1);
      default:                    loadValue = '0;
    endcase
  end

  lcd_delay_counter #(
    .W (LCD_CNT_W)
  ) u_delay (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (load),
    .load_value (loadValue),
    .expired    (expired)
  );

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state               <= LCD_IDLE;
      dataReg             <= '0;
      rsReg               <= 1'b0;
      oReady              <= 1'b1;
      oDone               <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= '0;
    end else begin
      state <= nextState;
      if (accept) begin
        dataReg <= iData;
        rsReg   <= iRS;
      end
      oReady              <= (nextState == LCD_IDLE);
      oDone               <= (nextState == LCD_DONE);
      oLCD_Enabled        <= (nextState == LCD_HI_PULSE) || (nextState == LCD_LO_PULSE);
      oLCD_RegisterSelect <= (nextState == LCD_IDLE) ? 1'b0 : rsNext;
      case (nextState)
        LCD_HI_SETUP, LCD_HI_PULSE, LCD_NIB_GAP:  oLCD_Data <= byteNext[7:4];
        LCD_LO_SETUP, LCD_LO_PULSE, LCD_BYTE_GAP: oLCD_Data <= byteNext[3:0];
        default:                                  oLCD_Data <= '0;
      endcase
    end
  end

  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;
  assign oDebugState             = state;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: timing model built from the LCD write rules,
// randomized bytes, back-to-back traffic, mid-transaction reset.
module tb_lcd_byte_writer;
  import lcd_pkg::*;

  localparam int T_E     = 12;
  localparam int T_SETUP = 2;
  localparam int T_NGAP  = 50;
  localparam int T_BGAP  = 2000;
  localparam int T_CGAP  = 82000;

  typedef struct {
    int          done_at;
    int          nrise;
    int          r1, w1, r2, w2;
    logic [3:0]  n1, n2;
    int          rs_bad;
  } obs_t;

  logic Clock = 1'b0;
  logic Reset;
  logic oE, oRS, oRW, oSF;
  logic [3:0] oD;
  lcd_wr_state_e dbg;

  int n_cmp = 0;
  int n_bad = 0;

  lcd_byte_writer_if bus ();

  always #5 Clock = ~Clock;

  lcd_byte_writer dut (
    .Clock                   (Clock),
    .Reset                   (Reset),
    .iValid                  (bus.valid),
    .iRS                     (bus.rs),
    .iData                   (bus.data),
    .oReady                  (bus.ready),
    .oDone                   (bus.done),
    .oLCD_Enabled            (oE),
    .oLCD_RegisterSelect     (oRS),
    .oLCD_Data               (oD),
    .oLCD_ReadWrite          (oRW),
    .oLCD_StrataFlashControl (oSF),
    .oDebugState             (dbg)
  );

  // Reference timing: cycle numbers counted from the acceptance edge (cycle 1 follows it).
  function automatic int post_wait(input logic rs, input logic [7:0] d);
`ifdef LCD_CLEAR_DELAY_EN
    if (!rs && (d == 8'h01 || d == 8'h02)) return T_CGAP;
`endif
    return T_BGAP;
  endfunction

  function automatic int done_cycle(input logic rs, input logic [7:0] d);
    return T_SETUP + T_E + T_NGAP + T_SETUP + T_E + post_wait(rs, d) + 1;
  endfunction

  task automatic send(input logic rs, input logic [7:0] d);
    int w = 0;
    while (bus.ready !== 1'b1 && w < 100000) begin
      @(negedge Clock);
      w++;
    end
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready_timeout: ready=%b want 1", bus.ready);
    end
    bus.valid = 1'b1;
    bus.rs    = rs;
    bus.data  = d;
    @(posedge Clock);
    #1 bus.valid = 1'b0;
  endtask

  task automatic observe(input logic exp_rs, input int limit, output obs_t o);
    logic prev_e = 1'b0;
    o = '{done_at: -1, nrise: 0, r1: -1, w1: 0, r2: -1, w2: 0, n1: 4'hx, n2: 4'hx, rs_bad: 0};
    for (int n = 1; n <= limit; n++) begin
      @(negedge Clock);
      if (oE === 1'b1 && prev_e === 1'b0) begin
        o.nrise++;
        if (o.nrise == 1) begin o.r1 = n; o.n1 = oD; end
        if (o.nrise == 2) begin o.r2 = n; o.n2 = oD; end
      end
      if (oE === 1'b1 && o.nrise == 1) o.w1++;
      if (oE === 1'b1 && o.nrise == 2) o.w2++;
      if (oRS !== exp_rs) o.rs_bad++;
      prev_e = oE;
      if (bus.done === 1'b1) begin
        o.done_at = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset     = 1'b1;
    bus.valid = 1'b1;
    bus.rs    = 1'b1;
    bus.data  = 8'h55;
    repeat (3) @(negedge Clock);
    n_cmp++;
    if ({bus.ready, bus.done, oE, oRS, oD, oRW, oSF} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%b done=%b e=%b rs=%b d=%h rw=%b sf=%b want 1 0 0 0 0 0 1",
               bus.ready, bus.done, oE, oRS, oD, oRW, oSF);
    end
    Reset     = 1'b0;
    bus.valid = 1'b0;
    repeat (5) @(negedge Clock);
    n_cmp++;
    if (bus.ready !== 1'b1 || oE !== 1'b0 || oD !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_idle_hold: rdy=%b e=%b d=%h want 1 0 0", bus.ready, oE, oD);
    end
  endtask

  task automatic test_write_41();
    obs_t o;
    send(1'b1, 8'h41);
    observe(1'b1, 5000, o);
    n_cmp++;
    if (o.done_at !== done_cycle(1'b1, 8'h41)) begin
      n_bad++; $display("FAIL w41_done_cycle: got %0d want %0d", o.done_at, done_cycle(1'b1, 8'h41));
    end
    n_cmp++;
    if (o.nrise !== 2 || o.r1 !== T_SETUP + 1 || o.r2 !== 2 * T_SETUP + T_E + T_NGAP + 1) begin
      n_bad++; $display("FAIL w41_pulse_pos: n=%0d r1=%0d r2=%0d want 2 %0d %0d", o.nrise, o.r1, o.r2,
                        T_SETUP + 1, 2 * T_SETUP + T_E + T_NGAP + 1);
    end
    n_cmp++;
    if (o.w1 !== T_E || o.w2 !== T_E) begin
      n_bad++; $display("FAIL w41_pulse_width: w1=%0d w2=%0d want %0d", o.w1, o.w2, T_E);
    end
    n_cmp++;
    if (o.n1 !== 4'h4 || o.n2 !== 4'h1) begin
      n_bad++; $display("FAIL w41_nibbles: got %h %h want 4 1", o.n1, o.n2);
    end
    n_cmp++;
    if (o.rs_bad !== 0) begin
      n_bad++; $display("FAIL w41_rs: bad cycles %0d want 0", o.rs_bad);
    end
    @(negedge Clock);
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.done !== 1'b0 || oD !== 4'h0 || oRS !== 1'b0) begin
      n_bad++; $display("FAIL w41_back_idle: rdy=%b done=%b d=%h rs=%b want 1 0 0 0", bus.ready, bus.done, oD, oRS);
    end
  endtask

  task automatic test_clear_cmd();
    obs_t o;
    send(1'b0, 8'h01);
    observe(1'b0, 90000, o);
    n_cmp++;
    if (o.done_at !== done_cycle(1'b0, 8'h01)) begin
      n_bad++; $display("FAIL clear_done_cycle: got %0d want %0d", o.done_at, done_cycle(1'b0, 8'h01));
    end
    n_cmp++;
    if (o.n1 !== 4'h0 || o.n2 !== 4'h1 || o.rs_bad !== 0) begin
      n_bad++; $display("FAIL clear_nibbles: got %h %h rsbad=%0d want 0 1 0", o.n1, o.n2, o.rs_bad);
    end
  endtask

  task automatic test_random_bytes();
    obs_t o;
    logic rs;
    logic [7:0] d;
    for (int k = 0; k < 3; k++) begin
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (!rs && (d == 8'h01 || d == 8'h02)) d = 8'h38;
      send(rs, d);
      observe(rs, 5000, o);
      n_cmp++;
      if (o.done_at !== done_cycle(rs, d)) begin
        n_bad++; $display("FAIL rand_done_cycle[%0d]: got %0d want %0d", k, o.done_at, done_cycle(rs, d));
      end
      n_cmp++;
      if ({o.n1, o.n2} !== d || o.rs_bad !== 0 || o.w1 !== T_E || o.w2 !== T_E) begin
        n_bad++; $display("FAIL rand_byte[%0d]: got %h%h rsbad=%0d w=%0d/%0d want %h rs=%b w=%0d",
                          k, o.n1, o.n2, o.rs_bad, o.w1, o.w2, d, rs, T_E);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int NB = 3;
    logic [4:0] exp_q[$];
    logic [4:0] obs_q[$];
    int done_q[$];
    int exp_done[$];
    logic [4:0] pres[int];
    int period;
    int ready_cnt = 0;
    logic prev_e = 1'b0;
    logic [7:0] d;
    logic rs;
    period = done_cycle(1'b1, 8'h41) + 1;
    while (bus.ready !== 1'b1) @(negedge Clock);
    for (int e = 0; e < NB * period; e++) begin
      rs = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (!rs && (d == 8'h01 || d == 8'h02)) d = 8'h0C;
      bus.valid = 1'b1;
      bus.rs    = rs;
      bus.data  = d;
      if (e % period == 0) begin
        exp_q.push_back({rs, d[7:4]});
        exp_q.push_back({rs, d[3:0]});
        exp_done.push_back(e + period - 1);
      end
      @(posedge Clock);
      @(negedge Clock);
      if (oE === 1'b1 && prev_e === 1'b0) obs_q.push_back({oRS, oD});
      prev_e = oE;
      if (bus.done === 1'b1) done_q.push_back(e + 1);
      if (bus.ready === 1'b1) ready_cnt++;
    end
    bus.valid = 1'b0;
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL b2b_nibble_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL b2b_nibble[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (done_q !== exp_done) begin
      n_bad++; $display("FAIL b2b_done_cycles: got %p want %p", done_q, exp_done);
    end
    n_cmp++;
    if (ready_cnt !== NB) begin
      n_bad++; $display("FAIL b2b_idle_cycles: got %0d want %0d", ready_cnt, NB);
    end
    @(negedge Clock);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int rises = 0;
    logic prev_e;
    send(1'b1, 8'h41);
    repeat (T_SETUP + 4) @(negedge Clock);
    n_cmp++;
    if (oE !== 1'b1) begin
      n_bad++; $display("FAIL rmid_in_pulse: e=%b want 1", oE);
    end
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    n_cmp++;
    if (oE !== 1'b0 || oD !== 4'h0 || bus.ready !== 1'b1 || oRS !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++; $display("FAIL rmid_outputs: e=%b d=%h rdy=%b rs=%b done=%b want 0 0 1 0 0",
                        oE, oD, bus.ready, oRS, bus.done);
    end
    prev_e = oE;
    for (int n = 0; n < 2200; n++) begin
      @(negedge Clock);
      if (bus.done === 1'b1) dones++;
      if (oE === 1'b1 && prev_e === 1'b0) rises++;
      prev_e = oE;
    end
    n_cmp++;
    if (dones !== 0 || rises !== 0) begin
      n_bad++; $display("FAIL rmid_abandoned: done pulses %0d e rises %0d want 0 0", dones, rises);
    end
  endtask

  task automatic test_data_change();
    obs_t o;
    send(1'b1, 8'h41);
    bus.valid = 1'b1;
    bus.rs    = 1'b0;
    bus.data  = 8'hFF;
    fork
      observe(1'b1, 5000, o);
      begin
        repeat (1500) @(negedge Clock);
        bus.valid = 1'b0;
      end
    join
    n_cmp++;
    if (o.n1 !== 4'h4 || o.n2 !== 4'h1 || o.rs_bad !== 0) begin
      n_bad++; $display("FAIL chg_nibbles: got %h %h rsbad=%0d want 4 1 0", o.n1, o.n2, o.rs_bad);
    end
    n_cmp++;
    if (o.done_at !== done_cycle(1'b1, 8'h41)) begin
      n_bad++; $display("FAIL chg_done_cycle: got %0d want %0d", o.done_at, done_cycle(1'b1, 8'h41));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    bus.valid = 1'b0;
    bus.rs    = 1'b0;
    bus.data  = 8'h00;
    test_reset();
    test_write_41();
    test_clear_cmd();
    test_random_bytes();
    test_back_to_back();
    test_reset_mid();
    test_data_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
